// File: rtl/chiptune_synth_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | chiptune_synth_if : strobe inputs and audio/song outputs            |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface chiptune_synth_if;
    logic        sample_clk;
    logic        tick_clk;
    logic        audio_out;
    logic [12:0] audio_sample;
    logic [10:0] song_position;

    modport master (
        output sample_clk, tick_clk,
        input  audio_out, audio_sample, song_position
    );

    modport slave (
        input  sample_clk, tick_clk,
        output audio_out, audio_sample, song_position
    );
endinterface
`default_nettype wire

// File: rtl/chiptune_synth.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | chiptune_synth : pattern ROM sequencer, lead/bass squares, optional |
// | noise drum (CHIPTUNE_DRUM_EN), mixer and sigma-delta audio pin.     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module chiptune_synth #(
    parameter int TICKS_PER_ROW = 7,
    parameter int SONG_LEN      = 1536,
    parameter int DECAY_TICKS   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    chiptune_synth_if.slave bus
);
    localparam int               c_TCW        = (TICKS_PER_ROW > 1) ? $clog2(TICKS_PER_ROW) : 1;
    localparam int               c_DCW        = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
    localparam logic [c_TCW-1:0] c_TICK_LAST  = c_TCW'(TICKS_PER_ROW - 1);
    localparam logic [c_DCW-1:0] c_DECAY_LAST = c_DCW'(DECAY_TICKS - 1);
    localparam logic [10:0]      c_POS_LAST   = 11'(SONG_LEN - 1);
    localparam logic [12:0]      c_MIDSCALE   = 13'd4096;

    function automatic logic [15:0] base_inc(input logic [3:0] semi);
        case (semi)
            4'd0:    base_inc = 16'd4359;
            4'd1:    base_inc = 16'd4618;
            4'd2:    base_inc = 16'd4893;
            4'd3:    base_inc = 16'd5184;
            4'd4:    base_inc = 16'd5492;
            4'd5:    base_inc = 16'd5818;
            4'd6:    base_inc = 16'd6164;
            4'd7:    base_inc = 16'd6531;
            4'd8:    base_inc = 16'd6919;
            4'd9:    base_inc = 16'd7331;
            4'd10:   base_inc = 16'd7767;
            4'd11:   base_inc = 16'd8229;
            default: base_inc = 16'd0;
        endcase
    endfunction

    // 16-row phrase; odd-parity sections of the song lift the lead an octave
    function automatic logic [6:0] lead_byte(input logic [3:0] idx);
        case (idx)
            4'd0:    lead_byte = 7'h49;
            4'd2:    lead_byte = 7'h54;
            4'd4:    lead_byte = 7'h50;
            4'd6:    lead_byte = 7'h54;
            4'd7:    lead_byte = 7'h0C;
            4'd8:    lead_byte = 7'h47;
            4'd10:   lead_byte = 7'h4B;
            4'd12:   lead_byte = 7'h52;
            4'd14:   lead_byte = 7'h47;
            4'd15:   lead_byte = 7'h0F;
            default: lead_byte = 7'h00;
        endcase
    endfunction

    function automatic logic [6:0] bass_byte(input logic [3:0] idx);
        case (idx)
            4'd2:    bass_byte = 7'h29;
            4'd6:    bass_byte = 7'h24;
            4'd10:   bass_byte = 7'h27;
            4'd12:   bass_byte = 7'h0C;
            4'd14:   bass_byte = 7'h22;
            default: bass_byte = 7'h00;
        endcase
    endfunction

    function automatic logic [12:0] amp(input logic [3:0] env, input logic positive);
        logic [12:0] mag;
        mag = {3'd0, env, 6'd0};
        amp = positive ? mag : 13'd0 - mag;
    endfunction

    // Returns {env, decay count}; a retrigger or note-off overrides decay
    function automatic logic [c_DCW+3:0] env_step(
        input logic retrig, input logic off, input logic tick,
        input logic [3:0] env, input logic [c_DCW-1:0] dcnt
    );
        env_step = {env, dcnt};
        if (retrig)
            env_step = {4'd15, {c_DCW{1'b0}}};
        else if (off)
            env_step = {4'd0, {c_DCW{1'b0}}};
        else if (tick) begin
            if (dcnt == c_DECAY_LAST)
                env_step = {(env == 4'd0) ? 4'd0 : env - 4'd1, {c_DCW{1'b0}}};
            else
                env_step = {env, dcnt + c_DCW'(1)};
        end
    endfunction

    logic [c_TCW-1:0] r_tick_cnt;
    logic [10:0]      r_pos;
    logic             r_first;
    logic [12:0]      r_sample;
    logic [12:0]      r_acc;
    logic             r_audio_out;

    logic             w_tick_wrap;
    logic             w_row_start;
    logic [10:0]      w_next_pos;
    logic [10:0]      w_row_addr;
    logic [6:0]       w_lead_base;
    logic [6:0]       w_note [2];
    logic [12:0]      w_amp  [2];
    logic [12:0]      w_drum_amp;

    assign w_tick_wrap = (r_tick_cnt == c_TICK_LAST);
    assign w_row_start = bus.tick_clk && (w_tick_wrap || r_first);
    assign w_next_pos  = (r_pos == c_POS_LAST) ? 11'd0 : r_pos + 11'd1;
    assign w_row_addr  = w_tick_wrap ? w_next_pos : r_pos;
    assign w_lead_base = lead_byte(w_row_addr[3:0]);
    assign w_note[0]   = ((^w_row_addr[10:4]) && (w_lead_base != 7'd0) && (w_lead_base[3:0] < 4'd12))
                         ? w_lead_base + 7'h10 : w_lead_base;
    assign w_note[1]   = bass_byte(w_row_addr[3:0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
            r_pos      <= '0;
            r_first    <= 1'b1;
        end else if (bus.tick_clk) begin
            r_first <= 1'b0;
            if (w_tick_wrap) begin
                r_tick_cnt <= '0;
                r_pos      <= w_next_pos;
            end else begin
                r_tick_cnt <= r_tick_cnt + c_TCW'(1);
            end
        end
    end

    for (genvar v = 0; v < 2; v++) begin : g_square
        logic [15:0]      r_phase;
        logic [15:0]      r_inc;
        logic [3:0]       r_env;
        logic [c_DCW-1:0] r_dcnt;
        logic             w_retrig;
        logic             w_off;

        assign w_retrig = w_row_start && (w_note[v] != 7'd0) && (w_note[v][3:0] <  4'd12);
        assign w_off    = w_row_start && (w_note[v] != 7'd0) && (w_note[v][3:0] >= 4'd12);
        assign w_amp[v] = amp(r_env, r_phase[15]);

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_phase <= '0;
                r_inc   <= '0;
                r_env   <= '0;
                r_dcnt  <= '0;
            end else begin
                if (w_retrig) begin
                    r_phase <= '0;
                    r_inc   <= base_inc(w_note[v][3:0]) >> (3'd7 - w_note[v][6:4]);
                end else if (bus.sample_clk) begin
                    r_phase <= r_phase + r_inc;
                end
                {r_env, r_dcnt} <= env_step(w_retrig, w_off, bus.tick_clk, r_env, r_dcnt);
            end
        end
    end

`ifdef CHIPTUNE_DRUM_EN
    logic [14:0]      r_lfsr;
    logic [3:0]       r_drum_env;
    logic [c_DCW-1:0] r_drum_dcnt;
    logic [6:0]       w_drum_note;
    logic             w_drum_retrig;
    logic             w_drum_off;

    assign w_drum_note   = (w_row_addr[1:0] == 2'd2) ? 7'h01 :
                           (w_row_addr[3:0] == 4'd8) ? 7'h0C : 7'h00;
    assign w_drum_retrig = w_row_start && (w_drum_note != 7'd0) && (w_drum_note[3:0] <  4'd12);
    assign w_drum_off    = w_row_start && (w_drum_note != 7'd0) && (w_drum_note[3:0] >= 4'd12);
    assign w_drum_amp    = amp(r_drum_env, r_lfsr[0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lfsr      <= 15'h7FFF;
            r_drum_env  <= '0;
            r_drum_dcnt <= '0;
        end else begin
            if (bus.sample_clk)
                r_lfsr <= {r_lfsr[13:0], r_lfsr[14] ^ r_lfsr[13]};
            {r_drum_env, r_drum_dcnt} <= env_step(w_drum_retrig, w_drum_off, bus.tick_clk,
                                                  r_drum_env, r_drum_dcnt);
        end
    end
`else
    assign w_drum_amp = 13'd0;
`endif

    // Mix wraps modulo 2^13; the legal range 1216..6976 never reaches the wrap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sample    <= c_MIDSCALE;
            r_acc       <= '0;
            r_audio_out <= 1'b0;
        end else begin
            if (bus.sample_clk)
                r_sample <= c_MIDSCALE + w_amp[0] + w_amp[1] + w_drum_amp;
            {r_audio_out, r_acc} <= {1'b0, r_acc} + {1'b0, r_sample};
        end
    end

    assign bus.audio_sample  = r_sample;
    assign bus.audio_out     = r_audio_out;
    assign bus.song_position = r_pos;
endmodule
`default_nettype wire

// File: tb/tb_chiptune_synth.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_chiptune_synth : directed scenarios and random strobes against   |
// | an arithmetic song/voice model.  Rev 1.0                            |
// +--------------------------------------------------------------------+
module tb_chiptune_synth;
    localparam int TPR  = 7;
    localparam int SLEN = 1536;
    localparam int DEC  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    chiptune_synth_if bus ();

    chiptune_synth #(
        .TICKS_PER_ROW (TPR),
        .SONG_LEN      (SLEN),
        .DECAY_TICKS   (DEC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Song content: note bytes {oct, semi} per 16-row phrase
    int base_tab [12] = '{4359, 4618, 4893, 5184, 5492, 5818, 6164, 6531, 6919, 7331, 7767, 8229};
    int lead_tab [16] = '{'h49, 0, 'h54, 0, 'h50, 0, 'h54, 'h0C, 'h47, 0, 'h4B, 0, 'h52, 0, 'h47, 'h0F};
    int bass_tab [16] = '{0, 0, 'h29, 0, 0, 0, 'h24, 0, 0, 0, 'h27, 0, 'h0C, 0, 'h22, 0};
    int drum_tab [16] = '{0, 0, 1, 0, 0, 0, 1, 0, 'h0C, 0, 1, 0, 0, 0, 1, 0};

    // Model: envelopes as start level minus elapsed ticks / DEC
    int m_ticks;
    int m_phase [3];
    int m_inc   [3];
    int m_start [3];
    int m_since [3];
    int m_lfsr, m_smp, m_acc, m_out;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int env_of(input int v);
        int e;
        e = m_start[v] - m_since[v] / DEC;
        return (e < 0) ? 0 : e;
    endfunction

    function automatic int amp_of(input int v, input bit positive);
        return positive ? env_of(v) * 64 : -env_of(v) * 64;
    endfunction

    function automatic int note_for(input int v, input int row);
        int b;
        if (v == 0) begin
            b = lead_tab[row % 16];
            if (($countones(row >> 4) % 2 == 1) && b != 0 && (b % 16) < 12) b += 16;
        end else if (v == 1) begin
            b = bass_tab[row % 16];
        end else begin
            b = drum_tab[row % 16];
        end
        return b;
    endfunction

    task automatic model_reset();
        m_ticks = 0;
        for (int v = 0; v < 3; v++) begin
            m_phase[v] = 0; m_inc[v] = 0; m_start[v] = 0; m_since[v] = 0;
        end
        m_lfsr = 'h7FFF; m_smp = 4096; m_acc = 0; m_out = 0;
    endtask

    task automatic model_edge(input bit rn, input bit s, input bit t);
        int sum, mix, row, b, fb;
        if (!rn) begin
            model_reset();
            return;
        end
        sum   = m_acc + m_smp;
        m_out = (sum >= 8192) ? 1 : 0;
        m_acc = sum % 8192;
        if (s) begin
            mix = 4096 + amp_of(0, m_phase[0] >= 32768) + amp_of(1, m_phase[1] >= 32768);
`ifdef CHIPTUNE_DRUM_EN
            mix += amp_of(2, (m_lfsr % 2) == 1);
`endif
            for (int v = 0; v < 2; v++) m_phase[v] = (m_phase[v] + m_inc[v]) % 65536;
            fb     = ((m_lfsr >> 14) ^ (m_lfsr >> 13)) & 1;
            m_lfsr = ((m_lfsr << 1) | fb) & 'h7FFF;
            m_smp  = mix;
        end
        if (t) begin
            m_ticks++;
            for (int v = 0; v < 3; v++) m_since[v]++;
            row = -1;
            if (m_ticks == 1) row = 0;
            else if (m_ticks % TPR == 0) row = (m_ticks / TPR) % SLEN;
            if (row >= 0) begin
                for (int v = 0; v < 3; v++) begin
                    b = note_for(v, row);
                    if (b != 0) begin
                        m_since[v] = 0;
                        if (b % 16 < 12) begin
                            m_start[v] = 15;
                            if (v < 2) begin
                                m_phase[v] = 0;
                                m_inc[v]   = base_tab[b % 16] >> (7 - b / 16);
                            end
                        end else begin
                            m_start[v] = 0;
                        end
                    end
                end
            end
        end
    endtask

    task automatic step(input bit rn, input bit s, input bit t);
        rst_n = rn; bus.sample_clk = s; bus.tick_clk = t;
        @(posedge clk);
        model_edge(rn, s, t);
        #1;
        check("sample", bus.audio_sample, m_smp);
        check("pos", bus.song_position, (m_ticks / TPR) % SLEN);
        check("sdm", bus.audio_out, m_out);
    endtask

    task automatic strobes(input int n);
        repeat (n) begin
            step(1'b1, 1'b1, 1'b0);
            step(1'b1, 1'b0, 1'b0);
        end
    endtask

    function automatic int dev(input logic [12:0] smp);
        int d;
        d = int'(smp) - 4096;
        return (d < 0) ? -d : d;
    endfunction

    initial begin
        logic o0;
        model_reset();

        // Idle after reset: midscale, 50% density
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("rst_sample", bus.audio_sample, 4096);
        check("rst_out", bus.audio_out, 0);
        strobes(100);
        check("idle_sample", bus.audio_sample, 4096);
        check("idle_pos", bus.song_position, 0);
        o0 = bus.audio_out;
        step(1'b1, 1'b0, 1'b0);
        check("idle_alt", o0 ^ bus.audio_out, 1);

        // Forced row 0: A4 lead
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        strobes(1);
        check("a4_first", bus.audio_sample, 3136);
        strobes(35);
        check("a4_low36", bus.audio_sample, 3136);
        strobes(1);
        check("a4_high37", bus.audio_sample, 5056);

        // Decay one step, then coincident strobes at an envelope wrap
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        strobes(1);
        check("env14", bus.audio_sample, 4992);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        check("simul_pre", dev(bus.audio_sample), 896);
        step(1'b1, 1'b1, 1'b0);
        check("simul_post", dev(bus.audio_sample), 832);

        // Mid-note reset
        step(1'b0, 1'b0, 1'b0);
        check("mid_rst_sample", bus.audio_sample, 4096);
        check("mid_rst_pos", bus.song_position, 0);
        check("mid_rst_out", bus.audio_out, 0);
        strobes(3);
        check("mid_rst_silent", bus.audio_sample, 4096);

        // Row advance and full-song wrap
        for (int k = 0; k < 6; k++) step(1'b1, 1'($urandom_range(0, 1)), 1'b1);
        check("row0_hold", bus.song_position, 0);
        step(1'b1, 1'b0, 1'b1);
        check("row1", bus.song_position, 1);
        while (m_ticks < SLEN * TPR) step(1'b1, 1'($urandom_range(0, 1)), 1'b1);
        check("wrap_pos", bus.song_position, 0);
        for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 1'b1);
        check("wrap_hold", bus.song_position, 0);
        step(1'b1, 1'b0, 1'b1);
        check("wrap_row1", bus.song_position, 1);

        // Random strobes with occasional resets
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20000; i++) begin
            bit rn, s, t;
            rn = ($urandom_range(0, 3999) != 0);
            s  = ($urandom_range(0, 2) == 0);
            t  = ($urandom_range(0, 15) == 0);
            step(rn, s, t);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
